count_lead_unit: RTL
====================

Name: count_lead_unit

Overview:
- Two-stage pipelined execution unit for the MIPS32 CLZ and CLO instructions, placed in the EX stage alongside the ALU.
- Accepts rs operand, op select and destination tag from decode/issue under valid/ready handshake.
- Conditions the operand (inverts it for CLO), runs it through the 32-bit leading-zero count core, and presents a registered 32-bit result plus tag to writeback.
- Provides back-pressure and flush so it can stall or squash with the rest of the pipe.

Parameters:
- DATA_W, 32, operand and result width; only 32 is supported.
- TAG_W, 5, destination register tag width (rd).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  squash all in-flight ops; synchronous.
- in_valid  in  1  issue presents an op.
- in_ready  out  1  unit can accept an op this cycle.
- in_is_clo  in  1  1 = CLO (count leading ones), 0 = CLZ.
- in_operand  in  32  rs value.
- in_tag  in  5  rd index.
- out_valid  out  1  result available.
- out_ready  in  1  writeback consumes the result.
- out_result  out  32  count, 0..32, zero-extended.
- out_tag  out  5  rd index travelling with the result.
- busy  out  1  any stage holds a valid op.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high: `rst` is sampled on the rising edge of `clk`.
  - `rst` clears `s1_valid` and `s2_valid`, and zeroes all datapath registers.
  - After reset: `out_valid` = 0, `out_result` = 0, `out_tag` = 0, `busy` = 0, `in_ready` = 1.
- Stage S1 (condition):
  - Registers `cond` = `in_is_clo` ? ~`in_operand` : `in_operand`.
  - Also registers `tag` and `s1_valid`.
- Stage S2 (count):
  - Registers `lz(cond)`, zero-extended to 32 bits, together with `tag` and `s2_valid`.
  - `lz` counts leading zeros from bit 31 down to bit 0. `lz(0)` = 32.
  - For CLO, `lz(~x)` is the leading-ones count of x.
- Latency and throughput:
  - Latency is exactly 2 cycles from the accept edge to `out_valid`, when there is no back-pressure.
  - Throughput is 1 op per cycle.
- Handshake:
  - An op is accepted on the edge where `in_valid` && `in_ready`.
  - A result is consumed on the edge where `out_valid` && `out_ready`.
  - `s2_adv` = !`s2_valid` || `out_ready`.
  - `s1_adv` = !`s1_valid` || `s2_adv`.
  - `in_ready` = `s1_adv` && !`flush`. It is combinational from `out_ready`; there is no combinational path from `in_valid`.
  - Stalled stages hold data stable. `out_result` and `out_tag` must not change while `out_valid` && !`out_ready`.
  - When a stage advances with no incoming valid, its valid bit clears. Its data registers may hold stale values.
- Flush:
  - `flush` clears `s1_valid` and `s2_valid` on the same edge.
  - No op is accepted in the flush cycle.
  - A result being consumed in the flush cycle still counts as consumed.
  - `flush` takes effect regardless of `out_ready`.
- Simultaneous events:
  - `rst` has priority over `flush`, and `flush` has priority over accept.
  - Accept and consume in the same cycle with both stages full: the pipe shifts by one and stays full.
- Boundary values:
  - CLZ 0x00000000 → 32.
  - CLZ 0x80000000 → 0.
  - CLO 0xFFFFFFFF → 32.
  - CLO 0x7FFFFFFF → 0.
- `busy` = `s1_valid` || `s2_valid`.
- Reset during operation discards both stages with no output.

Optional Feature:
- Macro: `COUNT_LEAD_BYPASS_EN`.
- Defined:
  - S1 is a pass-through: conditioning is combinational into the S2 register.
  - Latency is 1 cycle.
  - `in_ready` = (!`s2_valid` || `out_ready`) && !`flush`.
  - All other rules are unchanged.
- Undefined: the 2-stage behaviour described above.

Decomposition:
- Shared package `count_pkg`:
  - `DATA_W` = 32.
  - `TAG_W` = 5.
  - `CNT_W` = 6.
  - Op-select encoding constants `OP_CLZ` = 0 and `OP_CLO` = 1.
  - Typedef for the stage record: {`valid`, `tag`, `data`}.
- Sub-module `lz_count32`:
  - Pure combinational 32-bit leading-zero priority encoder, 32-bit in, 6-bit out.
  - Instantiated between S1 and the S2 register.
  - Verified standalone by exhaustive single-bit walk.

Test Plan:
1. Reset, then CLZ 0x00010000 tag 3 with `out_ready` = 1 → `out_valid` 2 cycles later; result 15, tag 3; `busy` returns to 0 after consume.
2. Back-to-back over 4 cycles:
   - CLZ 0x00000000 → 32.
   - CLZ 0x80000000 → 0.
   - CLO 0xFFFFFFFF → 32.
   - CLO 0xF0000000 → 4.
   - Expect results on consecutive cycles in order, tags preserved.
3. Back-pressure: hold `out_ready` = 0 while issuing 3 ops.
   - `in_ready` drops after 2 accepts.
   - `out_result` is stable.
   - Releasing `out_ready` drains all 3 in order with no loss or duplication.
4. Flush with both stages full → `out_valid` = 0 and `busy` = 0 next cycle. An op presented in the flush cycle is not accepted and never emerges.
5. Assert `rst` mid-stream with 2 ops in flight → both discarded; outputs zero; next op CLZ 0x00000001 → result 31 with normal 2-cycle latency.
6. With `COUNT_LEAD_BYPASS_EN` defined: CLO 0xFFFF0000 → result 16 one cycle after accept; repeat scenario 3 → depth-1 back-pressure.

Source files
------------

// File: rtl/count_lead_unit_pkg.sv
// Shared definitions for the CLZ/CLO execution unit.
// Holds datapath widths, op-select encodings and the per-stage pipeline record.
// Optional build macro used by the unit: COUNT_LEAD_BYPASS_EN.
package count_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 5;
    localparam int unsigned CNT_W  = 6;

    localparam logic OP_CLZ = 1'b0;
    localparam logic OP_CLO = 1'b1;

    // One pipeline stage: valid bit, destination tag, payload.
    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } stage_t;

endpackage

// File: rtl/count_lead_unit_if.sv
// Issue/writeback bundle for count_lead_unit.
// Ports: in_valid/in_ready/in_is_clo/in_operand/in_tag (issue side),
//        out_valid/out_ready/out_result/out_tag (writeback side), flush, busy.
// master = issue/writeback logic around the unit, slave = the unit itself.
interface count_lead_unit_if;
    import count_pkg::*;

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              in_is_clo;
    logic [DATA_W-1:0] in_operand;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [TAG_W-1:0]  out_tag;
    logic              busy;

    modport master (
        output flush, in_valid, in_is_clo, in_operand, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, busy
    );

    modport slave (
        input  flush, in_valid, in_is_clo, in_operand, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, busy
    );

endinterface

// File: rtl/count_lead_unit_lz.sv
// lz_count32: combinational 32-bit leading-zero priority encoder.
// Ports: operand (32-bit in), count_c (6-bit out, 0..32; all-zero input gives 32).
module lz_count32
    import count_pkg::*;
(
    input  logic [DATA_W-1:0] operand,
    output logic [CNT_W-1:0]  count_c
);

    // Scan upward so the highest set bit is the last to write the result.
    always_comb begin
        count_c = CNT_W'(DATA_W);
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (operand[i]) begin
                count_c = CNT_W'(int'(DATA_W) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/count_lead_unit.sv
// count_lead_unit: pipelined MIPS32 CLZ/CLO unit for the EX stage.
// Ports: clk, rst (synchronous, active-high), bus (count_lead_unit_if.slave).
// Default: S1 registers the conditioned operand, S2 registers the count (latency 2).
// COUNT_LEAD_BYPASS_EN: S1 becomes combinational, only S2 is registered (latency 1).
module count_lead_unit
    import count_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    count_lead_unit_if.slave bus
);

    stage_t             s2_q;
    logic               s2_adv;
    logic [DATA_W-1:0]  cond_c;
    logic [CNT_W-1:0]   cnt_c;

    assign s2_adv = !s2_q.valid || bus.out_ready;

    lz_count32 u_lz (
        .operand (cond_c),
        .count_c (cnt_c)
    );

`ifdef COUNT_LEAD_BYPASS_EN

    // CLO is counted as the leading zeros of the inverted operand.
    assign cond_c       = (bus.in_is_clo == OP_CLO) ? ~bus.in_operand : bus.in_operand;
    assign bus.in_ready = s2_adv && !bus.flush;
    assign bus.busy     = s2_q.valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_q <= '0;
        end else if (bus.flush) begin
            s2_q.valid <= 1'b0;
        end else if (s2_adv) begin
            s2_q.valid <= bus.in_valid;
            if (bus.in_valid) begin
                s2_q.tag  <= bus.in_tag;
                s2_q.data <= DATA_W'(cnt_c);
            end
        end
    end

`else

    stage_t s1_q;
    logic   s1_adv;

    assign s1_adv       = !s1_q.valid || s2_adv;
    assign cond_c       = s1_q.data;
    assign bus.in_ready = s1_adv && !bus.flush;
    assign bus.busy     = s1_q.valid || s2_q.valid;

    // Stalled stages keep their contents; advancing stages without a valid
    // predecessor only drop their valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else if (bus.flush) begin
            s1_q.valid <= 1'b0;
            s2_q.valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_q.valid <= s1_q.valid;
                if (s1_q.valid) begin
                    s2_q.tag  <= s1_q.tag;
                    s2_q.data <= DATA_W'(cnt_c);
                end
            end
            if (s1_adv) begin
                s1_q.valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_q.tag  <= bus.in_tag;
                    s1_q.data <= (bus.in_is_clo == OP_CLO) ? ~bus.in_operand : bus.in_operand;
                end
            end
        end
    end

`endif

    assign bus.out_valid  = s2_q.valid;
    assign bus.out_result = s2_q.data;
    assign bus.out_tag    = s2_q.tag;

endmodule
